pc_stack: RTL and testbench

Parametrised program counter for the Sim-AC core.
- Supports sequential increment, absolute jump, and subroutine call/return through an internal return-address stack.
- Adds a stall/enable input and sticky stack-error flags.
- Sits between the control unit, which issues the jmp/call/ret commands, and instruction memory, which consumes addr_o.

---
 rtl/pc_stack.sv | 112 +++++++++++
 tb/tb_pc_stack.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// ============================================================================
//  Module   : pc_stack
//  Purpose  : Program counter with jump, call/return via a register-based
//             return-address stack, stall enable and sticky stack-error flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_stack #(
    parameter int               ADDR_W      = 5,
    parameter int               STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             jmp_en_i,
    input  logic                             call_en_i,
    input  logic                             ret_en_i,
    input  logic [ADDR_W-1:0]                jmp_addr_i,
    output logic [ADDR_W-1:0]                addr_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int                c_DW    = $clog2(STACK_DEPTH + 1);
    localparam logic [c_DW-1:0]   c_FULL  = c_DW'(STACK_DEPTH);
    localparam logic [c_DW-1:0]   c_EMPTY = '0;

    logic [ADDR_W-1:0] r_addr;
    logic [c_DW-1:0]   r_depth;
    logic              r_overflow;
    logic              r_underflow;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_full;
    logic              w_empty;
    logic              w_do_call;
    logic              w_do_ret;
    logic              w_push;
    logic [ADDR_W-1:0] w_ret_addr;
    logic [ADDR_W-1:0] w_top;

    assign w_full     = (r_depth == c_FULL);
    assign w_empty    = (r_depth == c_EMPTY);
    assign w_ret_addr = r_addr + ADDR_W'(1);

    // Priority decode: jump masks call, call masks return.
    assign w_do_call  = en_i && !jmp_en_i && call_en_i;
    assign w_do_ret   = en_i && !jmp_en_i && !call_en_i && ret_en_i;
    assign w_push     = w_do_call && !w_full;

    // Top-of-stack lives at index depth-1; no bypass of same-edge pushes.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_depth == c_DW'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_push && (r_depth == c_DW'(i))) begin
                r_stack[i] <= w_ret_addr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_addr      <= RESET_ADDR;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (en_i) begin
            if (jmp_en_i) begin
                r_addr <= jmp_addr_i;
            end else if (w_do_call) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_addr  <= jmp_addr_i;
                    r_depth <= r_depth + c_DW'(1);
                end
            end else if (w_do_ret) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_addr  <= w_top;
                    r_depth <= r_depth - c_DW'(1);
                end
            end else begin
                r_addr <= w_ret_addr;
            end
        end
    end

    assign addr_o      = r_addr;
    assign depth_o     = r_depth;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack.sv
// ============================================================================
//  Module   : tb_pc_stack
//  Purpose  : Directed self-checking bench for pc_stack (ADDR_W=5, DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_stack;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       jmp_en_i;
    logic       call_en_i;
    logic       ret_en_i;
    logic [4:0] jmp_addr_i;
    logic [4:0] addr_o;
    logic [2:0] depth_o;
    logic       full_o;
    logic       empty_o;
    logic       overflow_o;
    logic       underflow_o;

    int errors = 0;
    int checks = 0;

    pc_stack #(
        .ADDR_W      (5),
        .STACK_DEPTH (4),
        .RESET_ADDR  (5'd0)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .jmp_en_i    (jmp_en_i),
        .call_en_i   (call_en_i),
        .ret_en_i    (ret_en_i),
        .jmp_addr_i  (jmp_addr_i),
        .addr_o      (addr_o),
        .depth_o     (depth_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        en_i = 1'b1; jmp_en_i = 1'b0; call_en_i = 1'b0; ret_en_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; idle(); jmp_addr_i = 5'd0;
        step(); step();
        checks++;
        if ({addr_o, depth_o, empty_o, full_o, overflow_o, underflow_o} !== {5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: addr=%0d depth=%0d empty=%b full=%b ovf=%b udf=%b, want 0 0 1 0 0 0",
                     addr_o, depth_o, empty_o, full_o, overflow_o, underflow_o);
        end
        rst_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (addr_o !== 5'(i) || depth_o !== 3'd0 || empty_o !== 1'b1) begin
                errors++;
                $display("FAIL increment[%0d]: addr=%0d depth=%0d empty=%b, want %0d 0 1", i, addr_o, depth_o, empty_o, i);
            end
        end
    endtask

    task automatic test_jump_wrap();
        logic [4:0] exp_seq [8] = '{5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31, 5'd0};
        jmp_en_i = 1'b1; jmp_addr_i = 5'd25;
        for (int i = 0; i < 8; i++) begin
            step();
            idle();
            checks++;
            if (addr_o !== exp_seq[i] || depth_o !== 3'd0) begin
                errors++;
                $display("FAIL jump_wrap[%0d]: addr=%0d depth=%0d, want %0d 0", i, addr_o, depth_o, exp_seq[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        // cmd: 0=jmp 1=call 2=ret
        int         cmd     [5] = '{0, 1, 1, 2, 2};
        logic [4:0] tgt     [5] = '{5'd4, 5'd20, 5'd10, 5'd0, 5'd0};
        logic [4:0] exp_a   [5] = '{5'd4, 5'd20, 5'd10, 5'd21, 5'd5};
        logic [2:0] exp_d   [5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            idle();
            jmp_en_i = (cmd[i] == 0); call_en_i = (cmd[i] == 1); ret_en_i = (cmd[i] == 2);
            jmp_addr_i = tgt[i];
            step();
            checks++;
            if (addr_o !== exp_a[i] || depth_o !== exp_d[i]) begin
                errors++;
                $display("FAIL call_ret[%0d]: addr=%0d depth=%0d, want %0d %0d", i, addr_o, depth_o, exp_a[i], exp_d[i]);
            end
        end
        idle();
    endtask

    task automatic test_overflow_underflow();
        // start at addr 5, depth 0
        logic [4:0] tgt   [5] = '{5'd8, 5'd12, 5'd16, 5'd20, 5'd24};
        logic [4:0] ca    [5] = '{5'd8, 5'd12, 5'd16, 5'd20, 5'd20};
        logic [4:0] ra    [5] = '{5'd17, 5'd13, 5'd9, 5'd6, 5'd6};
        for (int i = 0; i < 5; i++) begin
            idle(); call_en_i = 1'b1; jmp_addr_i = tgt[i];
            step();
            checks++;
            if (addr_o !== ca[i] || depth_o !== 3'(i < 4 ? i + 1 : 4) || overflow_o !== (i == 4)
                || full_o !== (i >= 3) || underflow_o !== 1'b0) begin
                errors++;
                $display("FAIL overflow_call[%0d]: addr=%0d depth=%0d full=%b ovf=%b udf=%b, want addr %0d",
                         i, addr_o, depth_o, full_o, overflow_o, underflow_o, ca[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            idle(); ret_en_i = 1'b1;
            step();
            checks++;
            if (addr_o !== ra[i] || depth_o !== 3'(i < 4 ? 3 - i : 0) || underflow_o !== (i == 4)
                || overflow_o !== 1'b1 || empty_o !== (i >= 3)) begin
                errors++;
                $display("FAIL underflow_ret[%0d]: addr=%0d depth=%0d empty=%b ovf=%b udf=%b, want addr %0d",
                         i, addr_o, depth_o, empty_o, overflow_o, underflow_o, ra[i]);
            end
        end
        idle();
        step();
        checks++;
        if (addr_o !== 5'd7 || overflow_o !== 1'b1 || underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL sticky_flags: addr=%0d ovf=%b udf=%b, want 7 1 1", addr_o, overflow_o, underflow_o);
        end
    endtask

    task automatic test_stall_priority();
        // start at addr 7, depth 0
        en_i = 1'b0; jmp_en_i = 1'b1; call_en_i = 1'b1; ret_en_i = 1'b0; jmp_addr_i = 5'd30;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (addr_o !== 5'd7 || depth_o !== 3'd0) begin
                errors++;
                $display("FAIL stall[%0d]: addr=%0d depth=%0d, want 7 0", i, addr_o, depth_o);
            end
        end
        idle(); call_en_i = 1'b1; jmp_addr_i = 5'd3;
        step();
        jmp_en_i = 1'b1; call_en_i = 1'b1; ret_en_i = 1'b1; jmp_addr_i = 5'd7;
        step();
        checks++;
        if (addr_o !== 5'd7 || depth_o !== 3'd1) begin
            errors++;
            $display("FAIL prio_jmp: addr=%0d depth=%0d, want 7 1", addr_o, depth_o);
        end
        idle(); call_en_i = 1'b1; ret_en_i = 1'b1; jmp_addr_i = 5'd11;
        step();
        checks++;
        if (addr_o !== 5'd11 || depth_o !== 3'd2) begin
            errors++;
            $display("FAIL prio_call: addr=%0d depth=%0d, want 11 2", addr_o, depth_o);
        end
        idle(); ret_en_i = 1'b1;
        step(); step();
        checks++;
        if (addr_o !== 5'd8 || depth_o !== 3'd0) begin
            errors++;
            $display("FAIL prio_stack_intact: addr=%0d depth=%0d, want 8 0", addr_o, depth_o);
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle(); call_en_i = 1'b1; jmp_addr_i = 5'd16;
        step();
        jmp_addr_i = 5'd18;
        step();
        idle();
        checks++;
        if (addr_o !== 5'd18 || depth_o !== 3'd2) begin
            errors++;
            $display("FAIL async_setup: addr=%0d depth=%0d, want 18 2", addr_o, depth_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (addr_o !== 5'd0 || depth_o !== 3'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%0d depth=%0d ovf=%b udf=%b, want 0 0 0 0",
                     addr_o, depth_o, overflow_o, underflow_o);
        end
        #2 rst_i = 1'b1;
        step();
        checks++;
        if (addr_o !== 5'd1 || depth_o !== 3'd0) begin
            errors++;
            $display("FAIL after_release: addr=%0d depth=%0d, want 1 0", addr_o, depth_o);
        end
    endtask

    initial begin
        test_reset();
        test_jump_wrap();
        test_call_ret();
        test_overflow_underflow();
        test_stall_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
